mem_access: RTL

- Memory-access stage of the non-pipelined RV32I core. Sits between execute and write_back.
- Issues load/store requests to the data memory over a req/ack handshake, aligns and extends load data, and drives the write_back inputs.
- Non-memory instructions pass through with one registered cycle.
- Stalls fetch/execute while a memory transaction is outstanding.

---
 rtl/mem_access_pkg.sv | 36 +++
 rtl/mem_load_align.sv | 30 +++
 rtl/mem_access.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings,
// FSM state type and the byte-enable width.
package mem_access_pkg;

    // Load encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int BE_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword lane of a load word and sign- or
// zero-extends it according to funct3. Purely combinational.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] lane;

    // Move the addressed byte down to bit 0
    assign lane = rdata_i >> {addr_lo_i, 3'b000};

    // Width selection and extension
    always_comb begin
        data_o = lane;
        case (funct3_i)
            LB:      data_o = {{24{lane[7]}}, lane[7:0]};
            LH:      data_o = {{16{lane[15]}}, lane[15:0]};
            LW:      data_o = lane;
            LBU:     data_o = {24'h0, lane[7:0]};
            LHU:     data_o = {16'h0, lane[15:0]};
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues data-memory requests over a req/ack
// handshake, times out unanswered requests, aligns load data and drives
// write-back. Non-memory instructions pass through with one cycle latency.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_NUM        = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic                       i_mem_rd,
    input  logic                       i_mem_wr,
    input  logic [2:0]                 i_funct3,
    input  logic [DATA_WIDTH-1:0]      i_alu_result,
    input  logic [DATA_WIDTH-1:0]      i_rs2_data,
    input  logic                       i_rf_wr_en,
    input  logic [$clog2(REG_NUM)-1:0] i_rf_wr_addr,
    input  logic [ADDRESS_WIDTH-1:0]   i_pc,
    input  logic                       i_ecall,
    output logic                       o_stall,
    output logic                       o_dmem_req,
    output logic                       o_dmem_we,
    output logic [ADDRESS_WIDTH-1:0]   o_dmem_addr,
    output logic [BE_WIDTH-1:0]        o_dmem_be,
    output logic [DATA_WIDTH-1:0]      o_dmem_wdata,
    input  logic                       i_dmem_ack,
    input  logic [DATA_WIDTH-1:0]      i_dmem_rdata,
    output logic                       o_valid,
    output logic                       o_rf_wr_en,
    output logic [$clog2(REG_NUM)-1:0] o_rf_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_rf_wr_data,
    output logic [ADDRESS_WIDTH-1:0]   o_pc,
    output logic                       o_ecall,
    output logic                       o_misaligned,
    output logic                       o_bus_err
);

    localparam int RA_W  = $clog2(REG_NUM);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_next;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BE_WIDTH-1:0]    be_q, be_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [1:0]             lo_q, lo_d;
    logic [2:0]             f3_q, f3_d;
    logic                   cap_wen_q, cap_wen_d;
    logic                   valid_q, valid_d;
    logic                   rf_wr_en_q, rf_wr_en_d;
    logic [RA_W-1:0]        rf_wr_addr_q, rf_wr_addr_d;
    logic [DATA_WIDTH-1:0]  rf_wr_data_q, rf_wr_data_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                   ecall_q, ecall_d;
    logic                   mis_q, mis_d;
    logic                   berr_q, berr_d;

    logic                   mem_op;
    logic                   mis_now;
    logic [31:0]            load_data;

    assign mem_op   = i_mem_rd | i_mem_wr;
    assign mis_now  = is_misaligned(i_funct3, i_alu_result[1:0]);
    assign cnt_next = cnt_q + 1'b1;

    mem_load_align u_align (
        .rdata_i   (i_dmem_rdata),
        .addr_lo_i (lo_q),
        .funct3_i  (f3_q),
        .data_o    (load_data)
    );

    // Next-state, request and write-back field computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        f3_d         = f3_q;
        cap_wen_d    = cap_wen_q;
        valid_d      = 1'b0;
        rf_wr_en_d   = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        pc_d         = pc_q;
        ecall_d      = ecall_q;
        mis_d        = 1'b0;
        berr_d       = 1'b0;
        o_stall      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    // rd/pc/ecall are only consumed alongside o_valid, so
                    // loading them at accept time is safe for all paths.
                    rf_wr_addr_d = i_rf_wr_addr;
                    pc_d         = i_pc;
                    ecall_d      = i_ecall;
                    if (!mem_op) begin
                        valid_d      = 1'b1;
                        rf_wr_en_d   = i_rf_wr_en;
                        rf_wr_data_d = i_alu_result;
                    end else if (mis_now) begin
                        // Faulting address is left on the data bus for the trap handler
                        valid_d      = 1'b1;
                        mis_d        = 1'b1;
                        rf_wr_data_d = i_alu_result;
                    end else begin
                        o_stall   = 1'b1;
                        state_d   = WAIT;
                        cnt_d     = '0;
                        req_d     = 1'b1;
                        we_d      = i_mem_wr;
                        addr_d    = {i_alu_result[ADDRESS_WIDTH-1:2], 2'b00};
                        lo_d      = i_alu_result[1:0];
                        f3_d      = i_funct3;
                        cap_wen_d = i_rf_wr_en & i_mem_rd;
                        be_d      = 4'b1111;
                        wdata_d   = '0;
                        if (i_mem_wr) begin
                            case (i_funct3[1:0])
                                2'b00: begin
                                    be_d    = 4'b0001 << i_alu_result[1:0];
                                    wdata_d = {4{i_rs2_data[7:0]}};
                                end
                                2'b01: begin
                                    be_d    = 4'b0011 << i_alu_result[1:0];
                                    wdata_d = {2{i_rs2_data[15:0]}};
                                end
                                default: begin
                                    be_d    = 4'b1111;
                                    wdata_d = i_rs2_data;
                                end
                            endcase
                        end
                    end
                end
            end
            WAIT: begin
                o_stall = 1'b1;
                if (i_dmem_ack) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    req_d      = 1'b0;
                    valid_d    = 1'b1;
                    rf_wr_en_d = cap_wen_q;
                    if (!we_q) begin
                        rf_wr_data_d = load_data;
                    end
                end else if (cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_next;
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            f3_q         <= '0;
            cap_wen_q    <= 1'b0;
            valid_q      <= 1'b0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            pc_q         <= '0;
            ecall_q      <= 1'b0;
            mis_q        <= 1'b0;
            berr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            f3_q         <= f3_d;
            cap_wen_q    <= cap_wen_d;
            valid_q      <= valid_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            pc_q         <= pc_d;
            ecall_q      <= ecall_d;
            mis_q        <= mis_d;
            berr_q       <= berr_d;
        end
    end

    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;
    assign o_valid      = valid_q;
    assign o_rf_wr_en   = rf_wr_en_q;
    assign o_rf_wr_addr = rf_wr_addr_q;
    assign o_rf_wr_data = rf_wr_data_q;
    assign o_pc         = pc_q;
    assign o_ecall      = ecall_q;
    assign o_misaligned = mis_q;
    assign o_bus_err    = berr_q;

endmodule
